// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - op codes, fsm states and default width for the mips mul/div unit
package mips_muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mips_muldiv_step.sv
// rtl/mips_muldiv_step.sv - one shift-add multiply or restoring-divide iteration on unsigned magnitudes
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // multiply: {r,q} holds the partial product with the multiplier in q
        sum     = {1'b0, r_in} + {1'b0, (q_in[0] ? m : '0)};
        // divide: r is the partial remainder, q shifts the dividend out and the quotient in
        shifted = {r_in, q_in[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        if (is_div) begin
            // r_in < m keeps a non-negative diff below 2^WIDTH, so diff[WIDTH] is the borrow
            if (!diff[WIDTH]) begin
                r_out = diff[WIDTH-1:0];
                q_out = {q_in[WIDTH-2:0], 1'b1};
            end else begin
                r_out = shifted[WIDTH-1:0];
                q_out = {q_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            r_out = sum[WIDTH:1];
            q_out = {sum[0], q_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative mips hi/lo multiply/divide unit; MIPS_MULDIV_EARLY_OUT_EN skips RUN for zero operands
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e state, next_state;

    logic             is_div_q;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] a_q;
    logic [CW-1:0]    cnt;

    logic             is_div_in;
    logic             is_signed;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             early;

    logic [WIDTH-1:0]   r_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_div_in = (op == OP_DIV) || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        sa        = is_signed & a[WIDTH-1];
        sb        = is_signed & b[WIDTH-1];
        // the most-negative value maps onto itself, which is its correct unsigned magnitude
        abs_a     = sa ? -a : a;
        abs_b     = sb ? -b : b;
    end

`ifdef MIPS_MULDIV_EARLY_OUT_EN
    assign early = is_div_in ? (b == '0) : ((a == '0) || (b == '0));
`else
    assign early = 1'b0;
`endif

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .m      (m_q),
        .r_in   (r_q),
        .q_in   (q_q),
        .r_out  (r_nxt),
        .q_out  (q_nxt)
    );

    always_comb begin
        prod     = {r_q, q_q};
        prod_fix = neg_lo ? -prod : prod;
        quo_fix  = neg_lo ? -q_q : q_q;
        rem_fix  = neg_hi ? -r_q : r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = early ? FIX : RUN;
            RUN:     if (cnt == LAST) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q    <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            m_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            a_q         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q    <= is_div_in;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        r_q         <= '0;
                        a_q         <= a;
                        neg_lo      <= sa ^ sb;
                        if (is_div_in) begin
                            m_q    <= abs_b;
                            q_q    <= abs_a;
                            neg_hi <= sa;
                        end else begin
                            m_q    <= abs_a;
                            // a skipped multiply must still leave a zero product in {r,q}
                            q_q    <= early ? '0 : abs_b;
                            neg_hi <= sa ^ sb;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (is_div_q) begin
                        if (m_q == '0) begin
                            hi          <= a_q;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - self-checking bench for mips_muldiv_unit
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // reference: plain wide/int arithmetic following the mips hi/lo rules
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint      lx, ly;
        logic [63:0] p;
        int          sx, sy;
        ed = 1'b0;
        eh = '0;
        el = '0;
        if (o == OP_MULT) begin
            lx = longint'($signed(x));
            ly = longint'($signed(y));
            p  = 64'(lx * ly);
            eh = p[63:32];
            el = p[31:0];
        end else if (o == OP_MULTU) begin
            p  = {32'd0, x} * {32'd0, y};
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ed = 1'b1;
        end else if (o == OP_DIV) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                el = x;
                eh = '0;
            end else begin
                sx = x;
                sy = y;
                el = sx / sy;
                eh = sx % sy;
            end
        end else begin
            el = x / y;
            eh = x % y;
        end
    endfunction

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed);
        int lat;
        int exp_lat;
        exp_lat = WIDTH + 2;
`ifdef MIPS_MULDIV_EARLY_OUT_EN
        if (o[1] ? (y == 0) : (x == 0 || y == 0)) exp_lat = 2;
`endif
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        check({nm, " busy_after_start"}, busy, 1);
        check({nm, " dbz_cleared"}, div_by_zero, 0);
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " done_seen"}, done, 1);
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " busy_with_done"}, busy, 0);
        check({nm, " hi"}, hi, eh);
        check({nm, " lo"}, lo, el);
        check({nm, " dbz"}, div_by_zero, ed);
        @(negedge clk);
        check({nm, " done_one_cycle"}, done, 0);
    endtask

    vec_t        vecs[10];
    logic [31:0] eh, el;
    logic        ed;
    int          cnt;

    initial begin
        vecs[0] = '{OP_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{OP_DIVU,  32'd100,        32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{OP_DIV,   32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[6] = '{OP_MULT,  32'd0,          32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{OP_DIV,   32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{OP_DIVU,  32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[9] = '{OP_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dbz", div_by_zero, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);

        // mthi / mtlo in idle
        @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); hi_we = 1'b0;
        check("mthi hi", hi, 32'h1234);
        check("mthi lo_kept", lo, 32'h0000_0000);
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h5678;
        @(negedge clk); lo_we = 1'b0; hi_we = 1'b0;
        check("mthilo hi", hi, 32'h5678);
        check("mthilo lo", lo, 32'h5678);

        // writes and a second start while busy are ignored
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk); start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        cnt = 0;
        while (!done && cnt < 200) begin @(negedge clk); cnt++; end
        check("busy_ctl done_seen", done, 1);
        check("busy_ctl hi", hi, 32'd0);
        check("busy_ctl lo", lo, 32'd15);
        cnt = 0;
        repeat (60) begin @(negedge clk); if (done) cnt++; end
        check("busy_ctl extra_done", cnt, 0);

        // reset in the middle of a multiply
        start = 1'b1; op = OP_MULT; a = 32'hFFFF_FFF9; b = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst hi", hi, 0);
        check("midrst lo", lo, 0);
        check("midrst done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        repeat (50) begin @(negedge clk); if (done) cnt++; end
        check("midrst no_done", cnt, 0);
        run_op("after_rst", OP_MULT, 32'hFFFF_FFF9, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFC1, 1'b0);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx, ry;
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: rx = 32'd0;
                2: ry = 32'($urandom_range(1, 20));
                3: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                default: ;
            endcase
            model(ro, rx, ry, eh, el, ed);
            run_op($sformatf("rnd%0d op%0d a=%h b=%h", i, ro, rx, ry), ro, rx, ry, eh, el, ed);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit providing MIPS HI/LO semantics for mult, multu, div, divu, mthi and mtlo.
- Parametrised in operand width. A later revision of the same datapath family as the ALU.
- Sits beside the main ALU in the execute stage. The core stalls on busy and reads hi/lo after done (for mfhi/mflo).
- Multi-cycle. One shift-add (multiply) or restoring-subtract (divide) step per clock.

Parameters:
- WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits; must be >= 4.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- a  input  WIDTH  multiplicand / dividend (rs).
- b  input  WIDTH  multiplier / divisor (rt).
- hi_we  input  1  mthi write strobe.
- lo_we  input  1  mtlo write strobe.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; hi/lo are valid.
- div_by_zero  output  1  last completed op was a div/divu with b==0; sticky until next start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, internal counters and accumulators cleared.
- FSM: IDLE -> RUN -> FIX -> IDLE.
  - IDLE:
    - start=1 latches op, |a|, |b| and the result signs (absolute values for signed ops only).
    - Clears div_by_zero and the counter.
    - Goes to RUN. busy=1 from the next cycle.
  - RUN:
    - Performs one iteration per edge for exactly WIDTH edges.
    - The counter runs 0..WIDTH-1. The last step goes to FIX.
  - FIX:
    - Applies sign correction and writes hi/lo.
    - done=1 for exactly the following cycle; busy=0 from that cycle.
    - Goes to IDLE.
- Latency: start sampled at edge 0 gives done high in the cycle after edge WIDTH+1 (WIDTH+2 edges total). Latency is fixed regardless of operand values unless the optional feature is enabled.
- Multiply:
  - Forms the 2*WIDTH-bit product; hi=upper half, lo=lower half.
  - mult is signed two's complement. multu is unsigned.
- Divide:
  - lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative / -1: lo=most-negative (wraps), hi=0.
- Divide by zero:
  - hi=a (original dividend), lo=all ones, div_by_zero=1.
  - Same latency as a normal divide.
- start while busy, or during the done cycle's FIX transition: ignored (no queueing).
- hi_we/lo_we:
  - In IDLE with start=0: the register takes wdata at the next edge.
  - While busy: ignored.
  - Same cycle as start in IDLE: start wins and the write is dropped.
  - hi_we and lo_we together: both written.
- a, b and op changing after start: no effect; operands are captured at start.
- Reset mid-operation: immediately aborts to IDLE with all reset values; no done pulse.
- All arithmetic is internally WIDTH+1 bits (divide remainder) and 2*WIDTH bits (product). No X propagation on any output after reset.

Optional Feature:
- Macro: MIPS_MULDIV_EARLY_OUT_EN.
- Defined:
  - mult/multu with a==0 or b==0, and div/divu with b==0, skip RUN: IDLE -> FIX directly.
  - done follows in the cycle after edge 1.
  - Results are identical to the full path (product 0; the divide-by-zero values above).
- Undefined: fixed WIDTH+2 latency for all ops.

Decomposition:
- Package mips_muldiv_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - FSM state encoding IDLE/RUN/FIX.
  - default width constant.
- Sub-module mips_muldiv_step:
  - combinational single iteration (conditional add-and-shift for multiply, trial-subtract-and-shift for divide).
  - parametrised by WIDTH and instanced once in RUN.

Test Plan:
- mult a=7, b=-3 (FFFFFFFD) -> after 34 edges done=1, hi=FFFFFFFF, lo=FFFFFFEB, busy low with done.
- multu a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- div a=-7 (FFFFFFF9), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. Then div a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- divu a=100, b=0 -> hi=00000064, lo=FFFFFFFF, div_by_zero=1. Next start clears div_by_zero.
- Busy-path controls:
  - mthi 0x1234 in IDLE -> hi=00001234 next edge.
  - hi_we during busy -> ignored.
  - Second start during busy -> ignored, single done.
- Reset mid-op:
  - rst_n low at iteration 10 of mult -> busy=0, hi=lo=0 immediately, no done.
  - A fresh op after release completes correctly.
